alu_driver: RTL and testbench
=============================

# alu_driver

Command-side initiator for the 4-bit combinational ALU. Accepts operation commands (operands plus 3-bit select) through a valid/ready port and buffers them in a small FIFO. Drives them one at a time onto the ALU's `a`/`b`/`sel` inputs, captures `y`/`carry` and returns each result through a valid/ready response port with backpressure. It sits between the test/stimulus fabric and the ALU instance, and is the only driver of the ALU inputs.

## Interface
- `DEPTH`, 4, command FIFO depth in entries; power of two, ≥2.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  FIFO can accept; equals `!full`.
- `cmd_a`, `cmd_b`  in  4  operands.
- `cmd_sel`  in  3  ALU opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 XNOR, 110 SHL, 111 SHR.
- `alu_a`, `alu_b`  out  4  registered operands to the ALU.
- `alu_sel`  out  3  registered opcode to the ALU.
- `alu_y`  in  4  ALU result.
- `alu_carry`  in  1  ALU carry/borrow.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer accepts result.
- `rsp_y`  out  4  captured result.
- `rsp_carry`  out  1  captured carry.
- `rsp_sel`  out  3  opcode that produced the result.
- `busy`  out  1  high when the FSM is not IDLE or the FIFO is non-empty.
- `issued_cnt`  out  8  count of commands issued to the ALU, wraps 255→0.
- `mismatch`  out  1  sticky checker flag. Present in both builds; see Configuration.

## Operation
- FIFO: push on `cmd_valid && cmd_ready`. Pop only by the FSM. There is no bypass, so a full FIFO refuses a push even in a cycle where it pops.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop the head into `alu_a`/`alu_b`/`alu_sel`, increment `issued_cnt`, and go to ISSUE.
  - ISSUE: the ALU inputs have been stable for one cycle. At the end of the cycle, capture `alu_y`, `alu_carry` and `alu_sel` into `rsp_*`, set `rsp_valid`, and go to HOLD.
  - HOLD: `rsp_valid` = 1 and all `rsp_*` stay stable. On `rsp_ready`:
    - FIFO non-empty: pop and load the ALU registers in the same edge, then go to ISSUE.
    - FIFO empty: go to IDLE.
  - `rsp_valid` clears on the handshake edge.
- `alu_*` outputs hold the last issued command until the next pop.
- `rsp_carry` is captured exactly as presented by the ALU, including for logical opcodes. No masking.
- Reset values:
  - All outputs are 0, except `cmd_ready` = 1.
  - FIFO empty, FSM in IDLE, `issued_cnt` = 0, `mismatch` = 0.
- Reset mid-operation: any in-flight command and all FIFO contents are discarded. No response is produced for them.

## Timing
- Latency: a command accepted in cycle 0 into an idle, empty block gives the pop and ALU load at the end of cycle 1. Capture happens at the end of cycle 2, and `rsp_valid` is high in cycle 3.
- Peak throughput: one result per 2 cycles with `rsp_ready` held high.
- `cmd_ready` is registered-state-derived only. It has no combinational path from `rsp_ready`.
- `rsp_ready` asserted in the same cycle `rsp_valid` rises completes the handshake that cycle.

## Configuration
- `ALU_DRV_CHECK_EN` defined: an internal reference model computes the expected `{carry,y}` from `alu_a`/`alu_b`/`alu_sel` during ISSUE.
  - ADD: 5-bit sum.
  - SUB: 5-bit `{0,a}-{0,b}`; bit 4 is carry.
  - AND, OR, XOR, XNOR: carry 0.
  - SHL / SHR: 4-bit shift by 1, zero fill, carry 0.
  - Any inequality at capture sets `mismatch`. It stays set until reset.
- Not defined: the model is absent and `mismatch` is tied to 0.

## Test plan
- ADD: cmd a=9, b=8, sel=000 accepted in cycle 0 → `rsp_valid` in cycle 3 with y=1, carry=1, `rsp_sel`=000; `issued_cnt`=1.
- SUB and logical ops:
  - a=3, b=5, sel=001 → y=E, carry=1.
  - a=C, b=A, sel=101 → y=9.
  - a=9, sel=110 → y=2.
  - a=9, sel=111 → y=4.
- Backpressure/full: hold `rsp_ready`=0 and offer 6 commands back-to-back → exactly 1+DEPTH=5 are accepted, then `cmd_ready`=0. `rsp_*` stays stable throughout. Releasing `rsp_ready` drains all 5 in order, 2 cycles apart.
- Counter wrap: issue 256 commands → `issued_cnt` returns to 0.
- Checker (with `ALU_DRV_CHECK_EN`): the bench forces `alu_y` to 0 for one ADD of 1+1 → `mismatch`=1, sticky through later correct results. Cleared only by `rst`.
- Reset mid-op: assert `rst` for 1 cycle while in HOLD with 2 entries queued → next cycle `rsp_valid`=0, `busy`=0, `cmd_ready`=1, `alu_*`=0, and no further responses appear.

Source files
------------

// File: rtl/alu_driver.sv
// Command-side initiator for the 4-bit ALU: FIFO-buffered commands, one-at-a-time issue, held response.
// Optional reference checker enabled by defining ALU_DRV_CHECK_EN.
module alu_driver #(
  parameter int DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [3:0] cmd_a_i,
  input  logic [3:0] cmd_b_i,
  input  logic [2:0] cmd_sel_i,
  output logic [3:0] alu_a_o,
  output logic [3:0] alu_b_o,
  output logic [2:0] alu_sel_o,
  input  logic [3:0] alu_y_i,
  input  logic       alu_carry_i,
  output logic       rsp_valid_o,
  input  logic       rsp_ready_i,
  output logic [3:0] rsp_y_o,
  output logic       rsp_carry_o,
  output logic [2:0] rsp_sel_o,
  output logic       busy_o,
  output logic [7:0] issued_cnt_o,
  output logic       mismatch_o
);

  // state | meaning
  // IDLE  | nothing in flight, waiting for a queued command
  // ISSUE | ALU inputs stable, capture result at end of cycle
  // HOLD  | response presented, waiting for rsp_ready
  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  localparam int AW = $clog2(DEPTH);

  logic [10:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          full, empty, push, pop;

  state_t        state_q, state_d;
  logic          capture;
  logic [3:0]    alu_a_q, alu_b_q;
  logic [2:0]    alu_sel_q;
  logic          rsp_valid_q;
  logic [3:0]    rsp_y_q;
  logic          rsp_carry_q;
  logic [2:0]    rsp_sel_q;
  logic [7:0]    issued_q;
  logic          mismatch_q, mismatch_d;

  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  // No bypass: a full FIFO refuses even when popping this cycle.
  assign push  = cmd_valid_i && !full;

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_sel_i, cmd_b_i, cmd_a_i};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (!push && pop) cnt_q <= cnt_q - 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        capture = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (rsp_ready_i) begin
          pop     = !empty;
          state_d = empty ? IDLE : ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef ALU_DRV_CHECK_EN
  logic [4:0] ref_res;

  always_comb begin
    ref_res = 5'd0;
    case (alu_sel_q)
      3'b000: ref_res = {1'b0, alu_a_q} + {1'b0, alu_b_q};
      3'b001: ref_res = {1'b0, alu_a_q} - {1'b0, alu_b_q};
      3'b010: ref_res = {1'b0, alu_a_q & alu_b_q};
      3'b011: ref_res = {1'b0, alu_a_q | alu_b_q};
      3'b100: ref_res = {1'b0, alu_a_q ^ alu_b_q};
      3'b101: ref_res = {1'b0, ~(alu_a_q ^ alu_b_q)};
      3'b110: ref_res = {1'b0, alu_a_q[2:0], 1'b0};
      3'b111: ref_res = {2'b00, alu_a_q[3:1]};
      default: ref_res = 5'd0;
    endcase
    mismatch_d = mismatch_q | (capture && (ref_res != {alu_carry_i, alu_y_i}));
  end
`else
  assign mismatch_d = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_y_q     <= '0;
      rsp_carry_q <= 1'b0;
      rsp_sel_q   <= '0;
      issued_q    <= '0;
      mismatch_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mismatch_q <= mismatch_d;
      if (pop) begin
        {alu_sel_q, alu_b_q, alu_a_q} <= mem_q[rd_ptr_q];
        issued_q <= issued_q + 8'd1;
      end
      if (capture) begin
        rsp_valid_q <= 1'b1;
        rsp_y_q     <= alu_y_i;
        rsp_carry_q <= alu_carry_i;
        rsp_sel_q   <= alu_sel_q;
      end else if (state_q == HOLD && rsp_ready_i) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign cmd_ready_o  = !full;
  assign alu_a_o      = alu_a_q;
  assign alu_b_o      = alu_b_q;
  assign alu_sel_o    = alu_sel_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_y_o      = rsp_y_q;
  assign rsp_carry_o  = rsp_carry_q;
  assign rsp_sel_o    = rsp_sel_q;
  assign busy_o       = (state_q != IDLE) || !empty;
  assign issued_cnt_o = issued_q;
  assign mismatch_o   = mismatch_q;

endmodule

// File: tb/tb_alu_driver.sv
// Directed bench for alu_driver with a behavioural 4-bit ALU hanging off the alu_* port.
// Mismatch expectations follow ALU_DRV_CHECK_EN.
module tb_alu_driver;

`ifdef ALU_DRV_CHECK_EN
  localparam logic EXP_MM = 1'b1;
`else
  localparam logic EXP_MM = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_a = '0, cmd_b = '0;
  logic [2:0] cmd_sel = '0;
  logic [3:0] alu_a, alu_b, alu_y;
  logic [2:0] alu_sel;
  logic       alu_carry;
  logic       rsp_valid, rsp_carry, busy, mismatch;
  logic       rsp_ready = 1'b0;
  logic [3:0] rsp_y;
  logic [2:0] rsp_sel;
  logic [7:0] issued_cnt;
  logic       force_zero = 1'b0;
  logic [4:0] alu_res;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_driver #(.DEPTH(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_a_i(cmd_a), .cmd_b_i(cmd_b), .cmd_sel_i(cmd_sel),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_sel_o(alu_sel),
    .alu_y_i(alu_y), .alu_carry_i(alu_carry),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_y_o(rsp_y), .rsp_carry_o(rsp_carry), .rsp_sel_o(rsp_sel),
    .busy_o(busy), .issued_cnt_o(issued_cnt), .mismatch_o(mismatch)
  );

  // Behavioural ALU; force_zero corrupts y to exercise the checker.
  always_comb begin
    alu_res = 5'd0;
    case (alu_sel)
      3'b000: alu_res = {1'b0, alu_a} + {1'b0, alu_b};
      3'b001: alu_res = {1'b0, alu_a} - {1'b0, alu_b};
      3'b010: alu_res = {1'b0, alu_a & alu_b};
      3'b011: alu_res = {1'b0, alu_a | alu_b};
      3'b100: alu_res = {1'b0, alu_a ^ alu_b};
      3'b101: alu_res = {1'b0, ~(alu_a ^ alu_b)};
      3'b110: alu_res = {1'b0, alu_a[2:0], 1'b0};
      default: alu_res = {2'b00, alu_a[3:1]};
    endcase
    alu_y     = force_zero ? 4'd0 : alu_res[3:0];
    alu_carry = alu_res[4];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready);
    end
    vectors++;
    if ({rsp_valid, rsp_y, rsp_carry, rsp_sel, busy, mismatch} !== 11'd0) begin
      miscompares++;
      $display("FAIL reset_rsp: got v=%b y=%h c=%b s=%h busy=%b mm=%b expected all 0",
               rsp_valid, rsp_y, rsp_carry, rsp_sel, busy, mismatch);
    end
    vectors++;
    if ({alu_a, alu_b, alu_sel, issued_cnt} !== 19'd0) begin
      miscompares++;
      $display("FAIL reset_alu: got a=%h b=%h s=%h cnt=%0d expected all 0", alu_a, alu_b, alu_sel, issued_cnt);
    end
  endtask

  task automatic test_add_latency();
    do_reset();
    cmd_a = 4'h9; cmd_b = 4'h8; cmd_sel = 3'b000; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    vectors++;
    if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
      miscompares++; $display("FAIL add_cycle1: got valid=%b busy=%b expected 0/1", rsp_valid, busy);
    end
    tick();
    vectors++;
    if ({alu_a, alu_b, alu_sel, issued_cnt, rsp_valid} !== {4'h9, 4'h8, 3'b000, 8'd1, 1'b0}) begin
      miscompares++;
      $display("FAIL add_cycle2: got a=%h b=%h s=%h cnt=%0d v=%b expected 9/8/0/1/0",
               alu_a, alu_b, alu_sel, issued_cnt, rsp_valid);
    end
    tick();
    vectors++;
    if ({rsp_valid, rsp_y, rsp_carry, rsp_sel, issued_cnt} !== {1'b1, 4'h1, 1'b1, 3'b000, 8'd1}) begin
      miscompares++;
      $display("FAIL add_cycle3: got v=%b y=%h c=%b s=%h cnt=%0d expected 1/1/1/0/1",
               rsp_valid, rsp_y, rsp_carry, rsp_sel, issued_cnt);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    vectors++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL add_handshake: got valid=%b busy=%b expected 0/0", rsp_valid, busy);
    end
  endtask

  task automatic test_ops();
    logic [3:0] ta [4] = '{4'h3, 4'hC, 4'h9, 4'h9};
    logic [3:0] tb [4] = '{4'h5, 4'hA, 4'h0, 4'h0};
    logic [2:0] ts [4] = '{3'b001, 3'b101, 3'b110, 3'b111};
    logic [3:0] ey [4] = '{4'hE, 4'h9, 4'h2, 4'h4};
    logic       ec [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      int n;
      cmd_a = ta[i]; cmd_b = tb[i]; cmd_sel = ts[i]; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      n = 0;
      while (rsp_valid !== 1'b1 && n < 20) begin tick(); n++; end
      vectors++;
      if ({rsp_valid, rsp_y, rsp_carry, rsp_sel} !== {1'b1, ey[i], ec[i], ts[i]}) begin
        miscompares++;
        $display("FAIL op%0d: got v=%b y=%h c=%b s=%h expected 1/%h/%b/%h",
                 i, rsp_valid, rsp_y, rsp_carry, rsp_sel, ey[i], ec[i], ts[i]);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] ta [6] = '{4'h1, 4'h7, 4'h2, 4'hF, 4'h5, 4'h6};
    logic [3:0] tb [6] = '{4'h2, 4'h9, 4'h3, 4'h3, 4'hA, 4'h3};
    logic [2:0] ts [6] = '{3'b000, 3'b000, 3'b001, 3'b010, 3'b011, 3'b100};
    logic [3:0] ey [5] = '{4'h3, 4'h0, 4'hF, 4'h3, 4'hF};
    logic       ec [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    int accepted = 0;
    int got = 0;
    int last = 0;
    int n = 0;
    logic stable_ok = 1'b1;
    logic gap_ok = 1'b1;
    logic order_ok = 1'b1;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cmd_a = ta[i]; cmd_b = tb[i]; cmd_sel = ts[i]; cmd_valid = 1'b1;
      @(negedge clk);
      if (cmd_ready === 1'b1) accepted++;
      tick();
    end
    cmd_valid = 1'b0;
    vectors++;
    if (accepted != 5 || cmd_ready !== 1'b0) begin
      miscompares++; $display("FAIL bp_accept: got accepted=%0d ready=%b expected 5/0", accepted, cmd_ready);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if ({rsp_valid, rsp_y, rsp_carry, rsp_sel} !== {1'b1, 4'h3, 1'b0, 3'b000}) stable_ok = 1'b0;
    end
    vectors++;
    if (stable_ok !== 1'b1) begin
      miscompares++; $display("FAIL bp_stable: got stable=%b expected 1 (last y=%h)", stable_ok, rsp_y);
    end
    tick();
    rsp_ready = 1'b1;
    while (got < 5 && n < 40) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        if ({rsp_y, rsp_carry, rsp_sel} !== {ey[got], ec[got], ts[got]}) begin
          order_ok = 1'b0;
          $display("  drain entry %0d: y=%h c=%b s=%h", got, rsp_y, rsp_carry, rsp_sel);
        end
        if (got > 0 && cyc - last != 2) gap_ok = 1'b0;
        last = cyc;
        got++;
      end
      tick();
      n++;
    end
    rsp_ready = 1'b0;
    vectors++;
    if (got != 5 || order_ok !== 1'b1) begin
      miscompares++; $display("FAIL bp_drain: got %0d responses in_order=%b expected 5/1", got, order_ok);
    end
    vectors++;
    if (gap_ok !== 1'b1) begin
      miscompares++; $display("FAIL bp_spacing: got 2-cycle spacing=%b expected 1", gap_ok);
    end
    vectors++;
    if (issued_cnt !== 8'd5 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_end: got cnt=%0d busy=%b ready=%b expected 5/0/1", issued_cnt, busy, cmd_ready);
    end
  endtask

  task automatic test_counter_wrap();
    int sent = 0;
    int rsps = 0;
    int n = 0;
    do_reset();
    rsp_ready = 1'b1;
    cmd_a = 4'h4; cmd_b = 4'h1; cmd_sel = 3'b011;
    cmd_valid = 1'b1;
    while ((sent < 256 || busy === 1'b1) && n < 2000) begin
      @(negedge clk);
      if (cmd_valid && cmd_ready === 1'b1) sent++;
      if (rsp_valid === 1'b1) rsps++;
      tick();
      if (sent == 256) cmd_valid = 1'b0;
      n++;
    end
    rsp_ready = 1'b0;
    vectors++;
    if (issued_cnt !== 8'd0 || rsps != 256 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap: got cnt=%0d rsps=%0d busy=%b expected 0/256/0", issued_cnt, rsps, busy);
    end
  endtask

  task automatic test_checker();
    int n;
    do_reset();
    force_zero = 1'b1;
    cmd_a = 4'h1; cmd_b = 4'h1; cmd_sel = 3'b000; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin tick(); n++; end
    vectors++;
    if ({rsp_valid, rsp_y, mismatch} !== {1'b1, 4'h0, EXP_MM}) begin
      miscompares++;
      $display("FAIL chk_forced: got v=%b y=%h mm=%b expected 1/0/%b", rsp_valid, rsp_y, mismatch, EXP_MM);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    force_zero = 1'b0;
    cmd_a = 4'h2; cmd_b = 4'h3; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin tick(); n++; end
    vectors++;
    if ({rsp_valid, rsp_y, mismatch} !== {1'b1, 4'h5, EXP_MM}) begin
      miscompares++;
      $display("FAIL chk_sticky: got v=%b y=%h mm=%b expected 1/5/%b", rsp_valid, rsp_y, mismatch, EXP_MM);
    end
    do_reset();
    vectors++;
    if (mismatch !== 1'b0) begin
      miscompares++; $display("FAIL chk_clear: got mm=%b expected 0", mismatch);
    end
  endtask

  task automatic test_reset_midop();
    int n = 0;
    logic seen = 1'b0;
    do_reset();
    cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cmd_a = 4'(i + 1); cmd_b = 4'h2; cmd_sel = 3'b000;
      tick();
    end
    cmd_valid = 1'b0;
    while (rsp_valid !== 1'b1 && n < 20) begin tick(); n++; end
    vectors++;
    if (rsp_valid !== 1'b1 || busy !== 1'b1) begin
      miscompares++; $display("FAIL mid_hold: got valid=%b busy=%b expected 1/1", rsp_valid, busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if ({rsp_valid, busy, cmd_ready, alu_a, alu_b, alu_sel} !== {1'b0, 1'b0, 1'b1, 11'd0}) begin
      miscompares++;
      $display("FAIL mid_reset: got v=%b busy=%b rdy=%b a=%h b=%h s=%h expected 0/0/1/0/0/0",
               rsp_valid, busy, cmd_ready, alu_a, alu_b, alu_sel);
    end
    rsp_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) seen = 1'b1;
      tick();
    end
    rsp_ready = 1'b0;
    vectors++;
    if (seen !== 1'b0 || issued_cnt !== 8'd0) begin
      miscompares++; $display("FAIL mid_no_rsp: got seen=%b cnt=%0d expected 0/0", seen, issued_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_add_latency();
    test_ops();
    test_backpressure();
    test_counter_wrap();
    test_checker();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
